// File: rtl/riscv_data_mem_if.sv
// CPU data-memory bus plus the TX byte stream that drains the MMIO FIFO.
interface riscv_data_mem_if;
    logic        MemWrite;
    logic [31:0] Mem_WrAddr;
    logic [31:0] Mem_WrData;
    logic [31:0] ReadData;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output MemWrite, Mem_WrAddr, Mem_WrData, tx_ready,
        input  ReadData, tx_data, tx_valid
    );

    modport slave (
        input  MemWrite, Mem_WrAddr, Mem_WrData, tx_ready,
        output ReadData, tx_data, tx_valid
    );
endinterface

// File: rtl/riscv_data_mem.sv
// Data RAM with an MMIO window: TX byte FIFO, FIFO status and a free-running cycle counter.
module riscv_data_mem #(
    parameter int unsigned MEM_WORDS  = 64,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'h0000_1000
) (
    input logic              clk,
    input logic              reset,
    riscv_data_mem_if.slave  bus
);
    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [31:0]   RAM_BYTES = 32'(MEM_WORDS * 4);
    localparam logic [29:0]   TXDATA_WA = MMIO_BASE[31:2];
    localparam logic [29:0]   STATUS_WA = TXDATA_WA + 30'd1;
    localparam logic [29:0]   CYCLE_WA  = TXDATA_WA + 30'd2;
    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

    logic [31:0]   ram [MEM_WORDS];
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic [31:0]   cycle_cnt;

    logic [29:0]   word_addr;
    logic [AW-1:0] ram_idx;
    logic          ram_hit;
    logic          wr_en;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic [31:0]   status_word;
    logic          unused_addr_lsbs;

    // Decode; writes are suppressed while reset is asserted.
    assign word_addr        = bus.Mem_WrAddr[31:2];
    assign ram_idx          = bus.Mem_WrAddr[AW+1:2];
    assign ram_hit          = bus.Mem_WrAddr < RAM_BYTES;
    assign wr_en            = bus.MemWrite && reset;
    assign unused_addr_lsbs = ^bus.Mem_WrAddr[1:0];

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FIFO_FULL);
    assign pop        = !fifo_empty && bus.tx_ready;
    assign push_req   = wr_en && (word_addr == TXDATA_WA);
    // A full FIFO still accepts a push when its head leaves on the same edge.
    assign push_ok    = push_req && (!fifo_full || pop);

    assign bus.tx_valid = !fifo_empty;
    assign bus.tx_data  = fifo_mem[rd_ptr];

    assign status_word = {23'd0, 6'(count), overflow, fifo_full, fifo_empty};

    // RAM and FIFO storage carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en && ram_hit) begin
            ram[ram_idx] <= bus.Mem_WrData;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= bus.Mem_WrData[7:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end else if (wr_en && (word_addr == STATUS_WA) && bus.Mem_WrData[2]) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_cnt <= '0;
        end else if (wr_en && (word_addr == CYCLE_WA)) begin
            cycle_cnt <= bus.Mem_WrData;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    // Zero-latency load path for the single-cycle core.
    always_comb begin
        bus.ReadData = '0;
        if (ram_hit) begin
            bus.ReadData = ram[ram_idx];
        end else begin
            case (word_addr)
                STATUS_WA: bus.ReadData = status_word;
                CYCLE_WA:  bus.ReadData = cycle_cnt;
                default:   bus.ReadData = '0;
            endcase
        end
    end
endmodule
